permuter_swap_ctrl: RTL and testbench
=====================================

# permuter_swap_ctrl

Per-stage swap controller for one 2x2 permuter in the bufferless deflection router's permutation network. Each cycle it arbitrates between the two incoming flits using golden-flit priority, then oldest-first, then a round-robin tie-break. It gives the winner its preferred output half and registers the resulting `swap` select for the permuter. It also keeps the router-local golden-epoch counter that decides which packet ID is golden.

## Interface
- `AGE_W`, 8: width of flit age field (unsigned; larger = older)
- `ID_W`, 4: width of packet ID field compared against golden ID
- `EPOCH`, 64: cycles per golden epoch (≥2)

- `clk`  in  1  clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `en`  in  1  advance enable; 0 = stall, all state held
- `valid0`, `valid1`  in  1  flit present on permuter input 0 / 1
- `age0`, `age1`  in  AGE_W  flit age
- `id0`, `id1`  in  ID_W  flit packet ID
- `pref0`, `pref1`  in  1  desired output index (0 = outFlit0, 1 = outFlit1) for that flit at this stage
- `swap`  out  1  registered select to permuter (1 = cross)
- `winner`  out  1  registered index of prioritized input
- `deflect`  out  1  registered: loser did not get its preferred output
- `anyValid`  out  1  registered: at least one input was valid
- `goldenId`  out  ID_W  current golden packet ID
- `epochTick`  out  1  one-cycle pulse, golden ID advanced

## Operation
- Golden flag per input: `gN = validN && (idN == goldenId)`, using the current pre-update `goldenId`.
- Winner selection when `en` = 1:
  - Both valid:
    - exactly one golden → it wins.
    - otherwise (neither golden, or both golden), the larger age wins (unsigned compare).
    - equal ages → winner = `rrPtr`, then `rrPtr` toggles. `rrPtr` toggles only when the tie-break is used.
  - Only one valid → that input wins.
  - Neither valid → winner = 0.
- `swap` = `pref[w] XOR w`, where `w` is the winner index. With no input valid, `swap` = 0.
- `deflect` = both valid and `pref0 == pref1`. Otherwise `deflect` = 0.
- `anyValid` = `valid0 | valid1`.
- Epoch counter `epochCnt`:
  - Counts 0..EPOCH-1 while `en` = 1.
  - At EPOCH-1 it wraps to 0, `goldenId` increments modulo 2^ID_W (wraps 2^ID_W-1 → 0), and `epochTick` is registered high for exactly the next cycle.
  - `epochTick` is 0 in all other cycles, including stalled cycles.
- `en` = 0: `swap`, `winner`, `deflect`, `anyValid`, `rrPtr`, `epochCnt` and `goldenId` all hold their values; `epochTick` drops to 0.

## Timing
- One-cycle latency: inputs sampled at edge k with `en` = 1 appear on `swap`/`winner`/`deflect`/`anyValid` after edge k. The permuter uses them in cycle k+1, aligned with the flit pipeline register.
- Wrap cycle: a decision taken in the same cycle that `epochCnt` wraps uses the old `goldenId`. The new `goldenId` is visible from the next cycle.
- Reset (async, any time, including mid-epoch or during a stall) immediately forces all of the following to 0: `swap`, `winner`, `deflect`, `anyValid`, `epochTick`, `goldenId`, `epochCnt`, `rrPtr`.
- First `epochTick` after reset release: the pulse follows the edge that samples `epochCnt` = EPOCH-1, i.e. after EPOCH enabled cycles.
- No combinational path from any input to any output.

## Test plan
- Age priority: both valid, neither golden, `age0`=5, `age1`=9, `pref1`=0, `pref0`=0 → next cycle `winner`=1, `swap`=1, `deflect`=1, `anyValid`=1.
- Golden override: `goldenId`=0, `id0`=0 with `age0`=1, `id1`=3 with `age1`=200, `pref0`=1, `pref1`=0 → `winner`=0, `swap`=1, `deflect`=0.
- Tie round-robin: four consecutive enabled cycles with equal ages, no golden, `pref0`=0, `pref1`=1 → `winner` sequence 0,1,0,1. `swap` sequence 0,0,0,0 (each winner gets its preference straight through). `deflect`=0 throughout.
- Single/none valid: only `valid1`, `pref1`=1 → `swap`=0, `winner`=1. Then no valid → `swap`=0, `winner`=0, `anyValid`=0.
- Epoch wrap with `EPOCH`=4, `ID_W`=2:
  - 16 enabled cycles → `epochTick` pulses after cycles 4, 8, 12, 16 and `goldenId` steps 1,2,3,0.
  - Holding `en`=0 for 3 cycles mid-epoch delays the next tick by exactly 3.
- Async reset mid-operation: assert `reset` between edges while `goldenId`=2 and `swap`=1 → all outputs 0 before the next edge. After release, the first tick comes after EPOCH enabled cycles.

Source files
------------

// File: rtl/permuter_swap_ctrl.sv
// Swap controller for one 2x2 permuter stage of a bufferless deflection router.
// Picks a winner by golden, then oldest, then round-robin, and registers the permuter select.
module permuter_swap_ctrl #(
  parameter int unsigned AGE_W = 8,
  parameter int unsigned ID_W  = 4,
  parameter int unsigned EPOCH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic            valid0,
  input  logic            valid1,
  input  logic [AGE_W-1:0] age0,
  input  logic [AGE_W-1:0] age1,
  input  logic [ID_W-1:0] id0,
  input  logic [ID_W-1:0] id1,
  input  logic            pref0,
  input  logic            pref1,
  output logic            swap,
  output logic            winner,
  output logic            deflect,
  output logic            anyValid,
  output logic [ID_W-1:0] goldenId,
  output logic            epochTick
);

  localparam int unsigned CntW = (EPOCH > 1) ? $clog2(EPOCH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(EPOCH - 1);

  logic            swap_q, swap_d;
  logic            winner_q, winner_d;
  logic            deflect_q, deflect_d;
  logic            any_q, any_d;
  logic            tick_q, tick_d;
  logic            rr_q, rr_d;
  logic [ID_W-1:0] golden_q, golden_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic g0, g1, tie_used, cnt_last;

  // Arbitration uses the golden ID as it stands before any wrap in this cycle.
  always_comb begin
    g0       = valid0 && (id0 == golden_q);
    g1       = valid1 && (id1 == golden_q);
    tie_used = 1'b0;
    winner_d = 1'b0;
    if (valid0 && valid1) begin
      if (g0 != g1) begin
        winner_d = g1;
      end else if (age0 > age1) begin
        winner_d = 1'b0;
      end else if (age1 > age0) begin
        winner_d = 1'b1;
      end else begin
        winner_d = rr_q;
        tie_used = 1'b1;
      end
    end else if (valid1) begin
      winner_d = 1'b1;
    end
    any_d     = valid0 | valid1;
    swap_d    = any_d ? ((winner_d ? pref1 : pref0) ^ winner_d) : 1'b0;
    deflect_d = valid0 && valid1 && (pref0 == pref1);
    rr_d      = tie_used ? ~rr_q : rr_q;
  end

  always_comb begin
    cnt_last = (cnt_q == CntLast);
    cnt_d    = cnt_last ? '0 : cnt_q + 1'b1;
    golden_d = cnt_last ? golden_q + 1'b1 : golden_q;
    tick_d   = en && cnt_last;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_q    <= 1'b0;
      winner_q  <= 1'b0;
      deflect_q <= 1'b0;
      any_q     <= 1'b0;
      tick_q    <= 1'b0;
      rr_q      <= 1'b0;
      golden_q  <= '0;
      cnt_q     <= '0;
    end else begin
      tick_q <= tick_d;
      if (en) begin
        swap_q    <= swap_d;
        winner_q  <= winner_d;
        deflect_q <= deflect_d;
        any_q     <= any_d;
        rr_q      <= rr_d;
        golden_q  <= golden_d;
        cnt_q     <= cnt_d;
      end
    end
  end

  assign swap      = swap_q;
  assign winner    = winner_q;
  assign deflect   = deflect_q;
  assign anyValid  = any_q;
  assign goldenId  = golden_q;
  assign epochTick = tick_q;

endmodule

// File: tb/tb_permuter_swap_ctrl.sv
// Directed bench for permuter_swap_ctrl with EPOCH=4, ID_W=2.
module tb_permuter_swap_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       valid0 = 1'b0, valid1 = 1'b0;
  logic [7:0] age0 = '0, age1 = '0;
  logic [1:0] id0 = '0, id1 = '0;
  logic       pref0 = 1'b0, pref1 = 1'b0;
  logic       swap, winner, deflect, anyValid, epochTick;
  logic [1:0] goldenId;

  int n_checks = 0;
  int n_fail = 0;

  permuter_swap_ctrl #(.AGE_W(8), .ID_W(2), .EPOCH(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .valid0   (valid0),
    .valid1   (valid1),
    .age0     (age0),
    .age1     (age1),
    .id0      (id0),
    .id1      (id1),
    .pref0    (pref0),
    .pref1    (pref1),
    .swap     (swap),
    .winner   (winner),
    .deflect  (deflect),
    .anyValid (anyValid),
    .goldenId (goldenId),
    .epochTick(epochTick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [7:0] a0, input logic [7:0] a1,
                       input logic [1:0] i0, input logic [1:0] i1, input logic p0, input logic p1);
    valid0 = v0; valid1 = v1; age0 = a0; age1 = a1;
    id0 = i0; id1 = i1; pref0 = p0; pref1 = p1;
  endtask

  // Pulses reset between edges, leaving the design in its reset state with counter at 0.
  task automatic do_reset();
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic check_outs(input string tag, input logic w, input logic s, input logic d,
                            input logic a);
    check({tag, ".winner"}, 32'(winner), 32'(w));
    check({tag, ".swap"}, 32'(swap), 32'(s));
    check({tag, ".deflect"}, 32'(deflect), 32'(d));
    check({tag, ".anyValid"}, 32'(anyValid), 32'(a));
  endtask

  initial begin
    #12;
    check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0);
    check("reset.goldenId", 32'(goldenId), 32'd0);
    check("reset.epochTick", 32'(epochTick), 32'd0);
    reset = 1'b0;
    en = 1'b1;

    // Age priority
    drive(1, 1, 8'd5, 8'd9, 2'd1, 2'd2, 0, 0);
    step();
    check_outs("age", 1'b1, 1'b1, 1'b1, 1'b1);

    // Golden override (goldenId still 0)
    drive(1, 1, 8'd1, 8'd200, 2'd0, 2'd3, 1, 0);
    step();
    check_outs("golden", 1'b0, 1'b1, 1'b0, 1'b1);

    // Tie round-robin from a fresh reset
    do_reset();
    drive(1, 1, 8'd7, 8'd7, 2'd1, 2'd2, 0, 1);
    step(); check_outs("tie1", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); check_outs("tie2", 1'b1, 1'b0, 1'b0, 1'b1);
    step(); check_outs("tie3", 1'b0, 1'b0, 1'b0, 1'b1);
    step(); check_outs("tie4", 1'b1, 1'b0, 1'b0, 1'b1);

    // Single and none valid
    drive(0, 1, 8'd3, 8'd4, 2'd1, 2'd1, 0, 1);
    step(); check_outs("only1", 1'b1, 1'b0, 1'b0, 1'b1);
    drive(0, 0, 8'd3, 8'd4, 2'd1, 2'd1, 1, 1);
    step(); check_outs("none", 1'b0, 1'b0, 1'b0, 1'b0);

    // 16 enabled cycles: ticks after 4, 8, 12, 16
    do_reset();
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("epoch%0d.tick", i), 32'(epochTick), (i % 4 == 0) ? 32'd1 : 32'd0);
      check($sformatf("epoch%0d.gid", i), 32'(goldenId), 32'((i / 4) % 4));
    end

    // Stall mid-epoch: tick slides by 3 cycles, outputs hold
    do_reset();
    drive(1, 1, 8'd5, 8'd9, 2'd1, 2'd2, 0, 0);
    step(); step();
    check_outs("prestall", 1'b1, 1'b1, 1'b1, 1'b1);
    en = 1'b0;
    drive(0, 0, 8'd0, 8'd0, 2'd0, 2'd0, 1, 1);
    for (int i = 1; i <= 3; i++) begin
      step();
      check_outs($sformatf("stall%0d", i), 1'b1, 1'b1, 1'b1, 1'b1);
      check($sformatf("stall%0d.tick", i), 32'(epochTick), 32'd0);
      check($sformatf("stall%0d.gid", i), 32'(goldenId), 32'd0);
    end
    en = 1'b1;
    drive(1, 1, 8'd5, 8'd9, 2'd1, 2'd2, 0, 0);
    step();
    check("resume3.tick", 32'(epochTick), 32'd0);
    step();
    check("resume4.tick", 32'(epochTick), 32'd1);
    check("resume4.gid", 32'(goldenId), 32'd1);

    // Async reset with goldenId=2 and swap=1
    do_reset();
    drive(1, 1, 8'd7, 8'd7, 2'd1, 2'd2, 0, 1);
    for (int i = 1; i <= 7; i++) step();
    drive(0, 1, 8'd0, 8'd0, 2'd1, 2'd1, 0, 0);
    step();
    check("prereset.gid", 32'(goldenId), 32'd2);
    check("prereset.swap", 32'(swap), 32'd1);
    check("prereset.tick", 32'(epochTick), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check_outs("async", 1'b0, 1'b0, 1'b0, 1'b0);
    check("async.gid", 32'(goldenId), 32'd0);
    check("async.tick", 32'(epochTick), 32'd0);
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check($sformatf("postrst%0d.tick", i), 32'(epochTick), (i == 4) ? 32'd1 : 32'd0);
    end
    check("postrst.gid", 32'(goldenId), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
